// File: rtl/move_stack.sv
// LIFO move buffer: compacts up to LANES pushed moves per cycle onto a register stack
// and returns one registered move per accepted pop.
module move_stack #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned MOVE_W = 16,
    parameter int unsigned LANES  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*MOVE_W-1:0]   formatted_moves,
    input  logic [LANES-1:0]          stack_write,
    input  logic                      pop,
    input  logic                      flush,
    output logic [MOVE_W-1:0]         pop_move,
    output logic                      pop_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned SW = AW + 2;

    logic [AW:0]       count_q, count_d;
    logic [MOVE_W-1:0] pop_move_q, pop_move_d;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q, overflow_d;

    logic [MOVE_W-1:0] mem [DEPTH];

    logic [CW-1:0]     lane_off [LANES];
    logic [CW-1:0]     n_push;
    logic [AW-1:0]     wr_addr [LANES];
    logic              pop_ok;
    logic              accept;
    logic              wr_en;
    logic [AW:0]       base;
    logic [SW-1:0]     net;
    logic [AW-1:0]     top_addr;

    // Each valid lane's slot offset is the number of valid lanes below it.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_off[i] = n_push;
            n_push      = n_push + CW'(stack_write[i]);
        end
    end

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        base     = count_q - (AW+1)'(pop_ok);
        net      = SW'(base) + SW'(n_push);
        accept   = net <= SW'(DEPTH);
        wr_en    = !flush && accept;
        top_addr = AW'(count_q - 1'b1);
        for (int i = 0; i < LANES; i++) begin
            wr_addr[i] = AW'(base) + AW'(lane_off[i]);
        end
    end

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        pop_valid_d = 1'b0;
        pop_move_d  = pop_move_q;
        if (flush) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop_ok) begin
                pop_valid_d = 1'b1;
                pop_move_d  = mem[top_addr];
            end
            // A burst that does not fit is dropped whole; the pop still completes.
            if (accept) begin
                count_d = net[AW:0];
            end else begin
                count_d    = base;
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            pop_move_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_move_q  <= pop_move_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && stack_write[i]) begin
                mem[wr_addr[i]] <= formatted_moves[i*MOVE_W +: MOVE_W];
            end
        end
    end

    assign count       = count_q;
    assign pop_move    = pop_move_q;
    assign pop_valid   = pop_valid_q;
    assign overflow    = overflow_q;
    assign empty       = (count_q == '0);
    assign almost_full = count_q > (AW+1)'(DEPTH - LANES);

endmodule
